hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, meaning MDU busy cycles loaded for mult/multu.
REQ-002 Parameter DIV_CYC, default 10, meaning MDU busy cycles loaded for div/divu.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, exposed as the ports below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 D_Tuse1, D_Tuse2  in  2 each  D-stage Tuse of rs/rt, in cycles from D.
REQ-007 D_ReadA1, D_ReadA2  in  5 each  D-stage source register addresses; 0 means no read.
REQ-008 D_Tnew  in  2  D-stage Tnew, in cycles from D.
REQ-009 D_WriteA  in  5  D-stage destination register address; 0 means no write.
REQ-010 D_MDUClass  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 D_MDStart  in  2  MDU start kind: 0 none, 1 mult/multu, 2 div/divu, 3 reserved (treated as 0).
REQ-012 Stall  out  1  freeze PC and the F/D register, and insert a bubble into E.
REQ-013 FwdD1, FwdD2  out  2 each  D operand source: 0 regfile, 1 E result, 2 M result, 3 W result.
REQ-014 E_WriteA, M_WriteA, W_WriteA  out  5 each  tracked destination address per stage.
REQ-015 E_Tnew, M_Tnew, W_Tnew  out  2 each  tracked remaining-cycles count per stage.
REQ-016 MDUBusy  out  1  MDU busy counter is nonzero.

Function
REQ-017 The block SHALL hold three stage records (E, M, W), each a {Tnew, WriteA} pair, updated every rising clk edge.
REQ-018 On a non-stall edge, the E record SHALL load {sat(D_Tnew-1), D_WriteA}; on a stall edge, the E record SHALL load {0, 0} (bubble).
REQ-019 On every edge, M SHALL load {sat(E_Tnew-1), E_WriteA} and W SHALL load {sat(M_Tnew-1), M_WriteA}, independent of Stall.
REQ-020 sat(x-1) SHALL floor at 0; a Tnew value never wraps to 3.
REQ-021 A stage X SHALL match operand i when D_ReadAi != 0 and X_WriteA == D_ReadAi.
REQ-022 Operand i SHALL raise a hazard when a matching E or M record has X_Tnew > D_Tuse_i.
REQ-023 W records SHALL never cause a hazard.
REQ-024 Stall SHALL be combinational: the OR of both operand hazards and the MDU hazard (REQ-029).
REQ-025 FwdDi SHALL select the youngest matching stage, priority E > M > W.
REQ-026 FwdDi SHALL be nonzero only when that youngest matching stage has Tnew == 0; otherwise FwdDi SHALL be 0.
REQ-027 An older match SHALL never be forwarded when a younger stage matches.
REQ-028 MDU counter: the counter SHALL be 4 bits wide and behave as follows.
  - On a non-stall edge with D_MDStart = 1, it SHALL load MULT_CYC.
  - On a non-stall edge with D_MDStart = 2, it SHALL load DIV_CYC.
  - Otherwise it SHALL decrement when nonzero and hold at 0.
  - A load SHALL take precedence over a decrement on the same edge.
REQ-029 MDU hazard SHALL be D_MDUClass && MDUBusy.
REQ-030 A start instruction stalled in D SHALL NOT load the counter; the load happens on the edge where it actually advances.
REQ-031 Simultaneous operand and MDU hazards SHALL produce a single Stall; records SHALL behave per REQ-018.

Reset
REQ-032 While rst_n = 0, all stage records and the MDU counter SHALL be 0, and therefore Stall = 0, FwdD1 = FwdD2 = 0, MDUBusy = 0, and all *_WriteA and *_Tnew = 0.
REQ-033 Reset assertion mid-stall or mid-MDU-operation SHALL clear state immediately, without waiting for clk.
REQ-034 After rst_n rises, the first clk edge SHALL behave as a normal non-stall edge.

Verification
REQ-035 ALU then beq: edge with D_Tnew=2, D_WriteA=8. Next cycle D_ReadA1=8, D_Tuse1=0 -> E_Tnew=1, so Stall=1 for one cycle. Following cycle: M_Tnew=0, Stall=0, FwdD1=2.
REQ-036 lw then add: D_Tnew=3, D_WriteA=9, then D_ReadA2=9, D_Tuse2=1. Cycle 1: E_Tnew=2 -> Stall=1. Cycle 2: M_Tnew=1 -> Stall=0, FwdD2=0 (forwarded later in E). Check E is bubble {0,0} after the stall edge.
REQ-037 Priority: E and M both hold WriteA=5 with Tnew 0, D_ReadA1=5 -> FwdD1=1. With D_ReadA1=0 -> FwdD1=0 and no stall.
REQ-038 div then mflo: edge with D_MDStart=2 -> MDUBusy=1 for 10 cycles. A D_MDUClass=1 instruction sees Stall=1 until the counter reaches 0, then Stall=0. A mult issued while stalled does not reload the counter.
REQ-039 Reset mid-div: counter=7, pull rst_n low between edges -> MDUBusy=0 and Stall=0 immediately, and all records read 0.
REQ-040 Saturation: D_Tnew=0 advanced -> E_Tnew=0, M_Tnew=0, never 3.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: Tnew/Tuse pipeline hazard unit for a 5-stage MIPS-style core.
// Tracks the destination register and remaining-result latency of the
// instructions in E, M and W, decides whether the instruction in D must stall,
// selects the forwarding source of both D operands, and models the busy time
// of the multiply/divide unit so that MDU-class instructions wait for it.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] D_Tuse1,
    input  logic [1:0] D_Tuse2,
    input  logic [4:0] D_ReadA1,
    input  logic [4:0] D_ReadA2,
    input  logic [1:0] D_Tnew,
    input  logic [4:0] D_WriteA,
    input  logic       D_MDUClass,
    input  logic [1:0] D_MDStart,
    output logic       Stall,
    output logic [1:0] FwdD1,
    output logic [1:0] FwdD2,
    output logic [4:0] E_WriteA,
    output logic [4:0] M_WriteA,
    output logic [4:0] W_WriteA,
    output logic [1:0] E_Tnew,
    output logic [1:0] M_Tnew,
    output logic [1:0] W_Tnew,
    output logic       MDUBusy
);

    // MDU busy lengths, truncated to the 4-bit counter width.
    localparam logic [3:0] LP_MULT_CYC = 4'(MULT_CYC);
    localparam logic [3:0] LP_DIV_CYC  = 4'(DIV_CYC);

    // Forwarding source encodings.
    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_E  = 2'd1;
    localparam logic [1:0] FWD_M  = 2'd2;
    localparam logic [1:0] FWD_W  = 2'd3;

    // Stage records: remaining cycles until the result exists, and destination.
    logic [1:0] r_e_tnew;
    logic [4:0] r_e_writea;
    logic [1:0] r_m_tnew;
    logic [4:0] r_m_writea;
    logic [1:0] r_w_tnew;
    logic [4:0] r_w_writea;
    logic [3:0] r_mdu_cnt;

    logic       w_haz1;
    logic       w_haz2;
    logic       w_mdu_haz;
    logic       w_stall;
    logic [1:0] w_fwd1;
    logic [1:0] w_fwd2;
    logic [3:0] w_mdu_nxt;

    // Decrement a Tnew value, flooring at zero so it never wraps to 3.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        logic [1:0] res;
        if (t == 2'd0) begin
            res = 2'd0;
        end else begin
            res = t - 2'd1;
        end
        return res;
    endfunction

    // A stage matches a source only when the source really reads a register.
    function automatic logic stage_match(input logic [4:0] ra, input logic [4:0] wa);
        return (ra != 5'd0) && (wa == ra);
    endfunction

    // Operand hazard: an E or M producer whose result arrives too late for D.
    // W is never a hazard because its result is always ready by then.
    function automatic logic op_hazard(
        input logic [4:0] ra,
        input logic [1:0] tuse,
        input logic [4:0] e_wa,
        input logic [1:0] e_tn,
        input logic [4:0] m_wa,
        input logic [1:0] m_tn
    );
        logic h;
        h = 1'b0;
        if (stage_match(ra, e_wa) && (e_tn > tuse)) begin
            h = 1'b1;
        end else if (stage_match(ra, m_wa) && (m_tn > tuse)) begin
            h = 1'b1;
        end else begin
            h = 1'b0;
        end
        return h;
    endfunction

    // Forward source: only the youngest matching stage is considered, and only
    // if its value already exists; otherwise D reads the register file and
    // the value is picked up by a later forwarding point.
    function automatic logic [1:0] op_fwd(
        input logic [4:0] ra,
        input logic [4:0] e_wa,
        input logic [1:0] e_tn,
        input logic [4:0] m_wa,
        input logic [1:0] m_tn,
        input logic [4:0] w_wa,
        input logic [1:0] w_tn
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (stage_match(ra, e_wa)) begin
            sel = (e_tn == 2'd0) ? FWD_E : FWD_RF;
        end else if (stage_match(ra, m_wa)) begin
            sel = (m_tn == 2'd0) ? FWD_M : FWD_RF;
        end else if (stage_match(ra, w_wa)) begin
            sel = (w_tn == 2'd0) ? FWD_W : FWD_RF;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Hazard detection, stall decision and forwarding selection for D.
    always_comb begin
        w_haz1    = op_hazard(D_ReadA1, D_Tuse1, r_e_writea, r_e_tnew, r_m_writea, r_m_tnew);
        w_haz2    = op_hazard(D_ReadA2, D_Tuse2, r_e_writea, r_e_tnew, r_m_writea, r_m_tnew);
        w_mdu_haz = D_MDUClass && (r_mdu_cnt != 4'd0);
        w_stall   = w_haz1 || w_haz2 || w_mdu_haz;
        w_fwd1    = op_fwd(D_ReadA1, r_e_writea, r_e_tnew, r_m_writea, r_m_tnew,
                           r_w_writea, r_w_tnew);
        w_fwd2    = op_fwd(D_ReadA2, r_e_writea, r_e_tnew, r_m_writea, r_m_tnew,
                           r_w_writea, r_w_tnew);
    end

    // Next MDU counter value: a start that actually leaves D loads the busy
    // time (a stalled start must not), otherwise count down towards zero.
    always_comb begin
        w_mdu_nxt = r_mdu_cnt;
        if (!w_stall && (D_MDStart == 2'd1)) begin
            w_mdu_nxt = LP_MULT_CYC;
        end else if (!w_stall && (D_MDStart == 2'd2)) begin
            w_mdu_nxt = LP_DIV_CYC;
        end else if (r_mdu_cnt != 4'd0) begin
            w_mdu_nxt = r_mdu_cnt - 4'd1;
        end else begin
            w_mdu_nxt = 4'd0;
        end
    end

    // Pipeline stage records and MDU counter; a stall injects a bubble into E
    // while M and W keep draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_tnew   <= 2'd0;
            r_e_writea <= 5'd0;
            r_m_tnew   <= 2'd0;
            r_m_writea <= 5'd0;
            r_w_tnew   <= 2'd0;
            r_w_writea <= 5'd0;
            r_mdu_cnt  <= 4'd0;
        end else begin
            if (w_stall) begin
                r_e_tnew   <= 2'd0;
                r_e_writea <= 5'd0;
            end else begin
                r_e_tnew   <= sat_dec(D_Tnew);
                r_e_writea <= D_WriteA;
            end
            r_m_tnew   <= sat_dec(r_e_tnew);
            r_m_writea <= r_e_writea;
            r_w_tnew   <= sat_dec(r_m_tnew);
            r_w_writea <= r_m_writea;
            r_mdu_cnt  <= w_mdu_nxt;
        end
    end

    assign Stall    = w_stall;
    assign FwdD1    = w_fwd1;
    assign FwdD2    = w_fwd2;
    assign E_WriteA = r_e_writea;
    assign M_WriteA = r_m_writea;
    assign W_WriteA = r_w_writea;
    assign E_Tnew   = r_e_tnew;
    assign M_Tnew   = r_m_tnew;
    assign W_Tnew   = r_w_tnew;
    assign MDUBusy  = (r_mdu_cnt != 4'd0);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed table-driven bench for hazard_ctrl plus hand-written
// sequences for MDU busy/stall behaviour and asynchronous reset mid-operation.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] D_Tuse1, D_Tuse2, D_Tnew, D_MDStart;
    logic [4:0] D_ReadA1, D_ReadA2, D_WriteA;
    logic       D_MDUClass;
    logic       Stall, MDUBusy;
    logic [1:0] FwdD1, FwdD2, E_Tnew, M_Tnew, W_Tnew;
    logic [4:0] E_WriteA, M_WriteA, W_WriteA;

    int total;
    int bad;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_Tuse1(D_Tuse1), .D_Tuse2(D_Tuse2),
        .D_ReadA1(D_ReadA1), .D_ReadA2(D_ReadA2),
        .D_Tnew(D_Tnew), .D_WriteA(D_WriteA),
        .D_MDUClass(D_MDUClass), .D_MDStart(D_MDStart),
        .Stall(Stall), .FwdD1(FwdD1), .FwdD2(FwdD2),
        .E_WriteA(E_WriteA), .M_WriteA(M_WriteA), .W_WriteA(W_WriteA),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .W_Tnew(W_Tnew),
        .MDUBusy(MDUBusy)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] tu1, tu2;
        logic [4:0] ra1, ra2;
        logic [1:0] tn;
        logic [4:0] wa;
        logic       cls;
        logic [1:0] mds;
        logic       x_st;
        logic [1:0] x_f1, x_f2;
        logic [1:0] x_et; logic [4:0] x_ea;
        logic [1:0] x_mt; logic [4:0] x_ma;
        logic [1:0] x_wt; logic [4:0] x_wa;
        logic       x_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] tu1, input logic [1:0] tu2,
                         input logic [4:0] ra1, input logic [4:0] ra2,
                         input logic [1:0] tn, input logic [4:0] wa,
                         input logic cls, input logic [1:0] mds);
        D_Tuse1 = tu1; D_Tuse2 = tu2; D_ReadA1 = ra1; D_ReadA2 = ra2;
        D_Tnew = tn; D_WriteA = wa; D_MDUClass = cls; D_MDStart = mds;
    endtask

    function automatic logic [21:0] state_vec();
        return {E_Tnew, E_WriteA, M_Tnew, M_WriteA, W_Tnew, W_WriteA, MDUBusy};
    endfunction

    initial begin
        int n;
        total = 0;
        bad   = 0;

        //            tu1   tu2   ra1   ra2   tn    wa     cls   mds  | st   f1    f2  | et    ea     mt    ma     wt    wa     busy
        vecs[0]  = '{2'd0, 2'd0, 5'd0, 5'd0, 2'd2, 5'd8,  1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 5'd0,  2'd0, 5'd0,  2'd0, 5'd0,  1'b0};
        vecs[1]  = '{2'd0, 2'd0, 5'd8, 5'd0, 2'd0, 5'd0,  1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd1, 5'd8,  2'd0, 5'd0,  2'd0, 5'd0,  1'b0};
        vecs[2]  = '{2'd0, 2'd0, 5'd8, 5'd0, 2'd0, 5'd0,  1'b0, 2'd0, 1'b0, 2'd2, 2'd0, 2'd0, 5'd0,  2'd0, 5'd8,  2'd0, 5'd0,  1'b0};
        vecs[3]  = '{2'd0, 2'd0, 5'd8, 5'd0, 2'd3, 5'd9,  1'b0, 2'd0, 1'b0, 2'd3, 2'd0, 2'd0, 5'd0,  2'd0, 5'd0,  2'd0, 5'd8,  1'b0};
        vecs[4]  = '{2'd0, 2'd1, 5'd0, 5'd9, 2'd2, 5'd10, 1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd2, 5'd9,  2'd0, 5'd0,  2'd0, 5'd0,  1'b0};
        vecs[5]  = '{2'd0, 2'd1, 5'd0, 5'd9, 2'd2, 5'd10, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 5'd0,  2'd1, 5'd9,  2'd0, 5'd0,  1'b0};
        vecs[6]  = '{2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd5,  1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd1, 5'd10, 2'd0, 5'd0,  2'd0, 5'd9,  1'b0};
        vecs[7]  = '{2'd0, 2'd0, 5'd5, 5'd0, 2'd0, 5'd5,  1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd0, 5'd5,  2'd0, 5'd10, 2'd0, 5'd0,  1'b0};
        vecs[8]  = '{2'd0, 2'd0, 5'd5, 5'd10,2'd0, 5'd0,  1'b0, 2'd0, 1'b0, 2'd1, 2'd3, 2'd0, 5'd5,  2'd0, 5'd5,  2'd0, 5'd10, 1'b0};
        vecs[9]  = '{2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0,  1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 2'd0, 5'd0,  2'd0, 5'd5,  2'd0, 5'd5,  1'b0};
        vecs[10] = '{2'd0, 2'd0, 5'd0, 5'd0, 2'd1, 5'd12, 1'b1, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, 5'd0,  2'd0, 5'd0,  2'd0, 5'd5,  1'b1};

        // Reset state
        rst_n = 1'b0;
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        check("reset_state", 32'(state_vec()), 32'd0);
        check("reset_haz", 32'({Stall, FwdD1, FwdD2}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table: outputs are checked after inputs settle, before the next edge.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vecs[i].tu1, vecs[i].tu2, vecs[i].ra1, vecs[i].ra2,
                  vecs[i].tn, vecs[i].wa, vecs[i].cls, vecs[i].mds);
            #1;
            check($sformatf("vec%0d_haz", i), 32'({Stall, FwdD1, FwdD2}),
                  32'({vecs[i].x_st, vecs[i].x_f1, vecs[i].x_f2}));
            check($sformatf("vec%0d_state", i), 32'(state_vec()),
                  32'({vecs[i].x_et, vecs[i].x_ea, vecs[i].x_mt, vecs[i].x_ma,
                       vecs[i].x_wt, vecs[i].x_wa, vecs[i].x_busy}));
        end

        // div issued in vec9 -> counter 10; vec10 saw count 10. A mult held in D
        // keeps stalling for counts 9..1 and must not reload the counter.
        @(negedge clk);
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd1, 5'd12, 1'b1, 2'd1);
        #1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!MDUBusy) break;
            if (Stall) n++;
            @(negedge clk);
            #1;
        end
        check("mdu_stall_cycles", 32'(n), 32'd9);
        check("mdu_release_stall", 32'(Stall), 32'd0);

        // The mult advances on this edge and loads 5 busy cycles.
        @(negedge clk);
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b0, 2'd0);
        #1;
        check("mult_in_e", 32'({E_Tnew, E_WriteA}), 32'({2'd0, 5'd12}));
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!MDUBusy) break;
            n++;
            @(negedge clk);
            #1;
        end
        check("mult_busy_cycles", 32'(n), 32'd5);

        // Reserved start kind does not load the counter.
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd0, 5'd0, 1'b1, 2'd3);
        @(negedge clk);
        #1;
        check("rsvd_start", 32'({Stall, MDUBusy}), 32'd0);

        // Reset mid-div: load div, run down to 7 with an lw stream, then reset
        // between edges with an MDU stall pending.
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd3, 5'd9, 1'b1, 2'd2);
        @(negedge clk);
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd3, 5'd9, 1'b0, 2'd0);
        repeat (3) @(negedge clk);
        D_MDUClass = 1'b1;
        #1;
        check("pre_reset_state", 32'(state_vec()),
              32'({2'd2, 5'd9, 2'd1, 5'd9, 2'd0, 5'd9, 1'b1}));
        check("pre_reset_stall", 32'(Stall), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_state", 32'(state_vec()), 32'd0);
        check("async_reset_haz", 32'({Stall, FwdD1, FwdD2}), 32'd0);

        // First edge after reset release is a normal advance.
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'd0, 2'd0, 5'd0, 5'd0, 2'd2, 5'd8, 1'b0, 2'd0);
        @(negedge clk);
        #1;
        check("post_reset_adv", 32'(state_vec()),
              32'({2'd1, 5'd8, 2'd0, 5'd0, 2'd0, 5'd0, 1'b0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
